// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl : shared types and constants for the upsampler controller.
//   PC_WIDTH    : default program counter / instruction memory address width.
//   iseqState_e : instruction sequencer states.
//   iseqErr_s   : sticky sequencer error bits, MSB first
//                 {timeout, prog_overrun, start_overrun}.
// ----------------------------------------------------------------------------
package ctrl;

   localparam int PC_WIDTH = 6;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LOAD,
      EXEC,
      NEXT
   } iseqState_e;

   typedef struct packed {
      logic timeout;
      logic prog_overrun;
      logic start_overrun;
   } iseqErr_s;

endpackage

// File: rtl/ctrl_wdog.sv
// ----------------------------------------------------------------------------
// ctrl_wdog : loadable down-counter with an expiry flag, used as the EXEC
// watchdog of ctrl_iseq. Compiled only when CTRL_ISEQ_WDOG_EN is defined, so
// the default build carries no unreferenced module.
// Ports:
//   clk      in   clock
//   rst      in   synchronous reset, active-low (count <= 0)
//   load     in   load load_val (has priority over en)
//   en       in   decrement while nonzero
//   load_val in   CNT_W  reload value
//   expired  out  count has reached zero
// ----------------------------------------------------------------------------
`ifdef CTRL_ISEQ_WDOG_EN
module ctrl_wdog #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign expired = (count == '0);

endmodule
`endif

// File: rtl/ctrl_iseq.sv
// ----------------------------------------------------------------------------
// ctrl_iseq : instruction sequencer of the upsampler controller.
// Walks the allocation program once per input sample: READ (memory read),
// LOAD (instruction register capture), EXEC (datapath running), NEXT (branch on
// the fetched lstg_f / upse_f flags). Every output comes straight from a flop.
//
// Optional feature: define CTRL_ISEQ_WDOG_EN to add an EXEC watchdog that
// abandons an instruction after WDOG_CYCLES cycles without mac_done and sets
// err[2]. Without it err[2] stays 0 and EXEC waits indefinitely.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous reset, active-low
//   start       in   new input sample (one-cycle pulse)
//   mac_done    in   datapath finished the current vector
//   lstg_f      in   last-stage flag from the instruction register
//   upse_f      in   last-upsampler-vector flag from the instruction register
//   imem_addr   out  PCWIDTH instruction memory address (= pc)
//   imem_rd     out  instruction memory read enable
//   fetch       out  instruction register capture strobe
//   exec_go     out  one-cycle datapath start
//   out_strobe  out  one output sample complete
//   sample_done out  program pass finished
//   busy        out  sequencer not idle
//   err         out  3 sticky errors {timeout, prog_overrun, start_overrun}
// ----------------------------------------------------------------------------
module ctrl_iseq
   import ctrl::*;
#(
   parameter int PCWIDTH     = ctrl::PC_WIDTH,
   parameter int PROG_LEN    = 64,
   parameter int WDOG_CYCLES = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               mac_done,
   input  logic               lstg_f,
   input  logic               upse_f,
   output logic [PCWIDTH-1:0] imem_addr,
   output logic               imem_rd,
   output logic               fetch,
   output logic               exec_go,
   output logic               out_strobe,
   output logic               sample_done,
   output logic               busy,
   output logic [2:0]         err
);

   if ((PROG_LEN < 1) || (PROG_LEN > (1 << PCWIDTH)) || (WDOG_CYCLES < 1)) begin : g_bad_cfg
      $error("ctrl_iseq: PROG_LEN or WDOG_CYCLES out of range");
   end

   localparam logic [PCWIDTH-1:0] PC_LAST = PCWIDTH'(PROG_LEN - 1);

   iseqState_e         state, state_nxt;
   logic [PCWIDTH-1:0] pc, pc_nxt;
   iseqErr_s           err_q, err_nxt;
   logic               out_nxt, done_nxt;
   logic               wdog_exp;

`ifdef CTRL_ISEQ_WDOG_EN
   localparam int               WDOG_W    = $clog2(WDOG_CYCLES + 1);
   localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(WDOG_CYCLES - 1);

   // Held at WDOG_CYCLES-1 outside EXEC, counts down inside it; reaching zero
   // in the WDOG_CYCLES-th EXEC cycle means the datapath never answered.
   ctrl_wdog #(
      .CNT_W(WDOG_W)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .load    (state != EXEC),
      .en      (state == EXEC),
      .load_val(WDOG_LOAD),
      .expired (wdog_exp)
   );
`else
   assign wdog_exp = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      err_nxt   = err_q;
      out_nxt   = 1'b0;
      done_nxt  = 1'b0;

      // A start that arrives while not idle (NEXT included) is dropped.
      if (start && (state != IDLE)) begin
         err_nxt.start_overrun = 1'b1;
      end

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = READ;
            end
         end
         READ: state_nxt = LOAD;
         LOAD: state_nxt = EXEC;
         EXEC: begin
            // exec_go is high exactly in the first EXEC cycle, where mac_done
            // still belongs to the previous vector and is ignored.
            if (mac_done && !exec_go) begin
               state_nxt = NEXT;
            end else if (wdog_exp) begin
               state_nxt       = IDLE;
               pc_nxt          = '0;
               err_nxt.timeout = 1'b1;
            end
         end
         NEXT: begin
            out_nxt = upse_f;
            if (lstg_f) begin
               pc_nxt    = '0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else if (pc == PC_LAST) begin
               pc_nxt               = '0;
               err_nxt.prog_overrun = 1'b1;
               state_nxt            = IDLE;
            end else begin
               pc_nxt    = pc + PCWIDTH'(1);
               state_nxt = READ;
            end
         end
         default: begin
            state_nxt = IDLE;
            pc_nxt    = '0;
         end
      endcase

`ifndef CTRL_ISEQ_WDOG_EN
      err_nxt.timeout = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         pc          <= '0;
         err_q       <= '0;
         imem_rd     <= 1'b0;
         fetch       <= 1'b0;
         exec_go     <= 1'b0;
         out_strobe  <= 1'b0;
         sample_done <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         err_q       <= err_nxt;
         imem_rd     <= (state_nxt == READ);
         fetch       <= (state_nxt == LOAD);
         exec_go     <= (state_nxt == EXEC) && (state != EXEC);
         out_strobe  <= out_nxt;
         sample_done <= done_nxt;
         busy        <= (state_nxt != IDLE);
      end
   end

   assign imem_addr = pc;
   assign err       = err_q;

endmodule

// File: tb/tb_ctrl_iseq.sv
// ----------------------------------------------------------------------------
// tb_ctrl_iseq : bench for ctrl_iseq with PROG_LEN=4, WDOG_CYCLES=8.
// Each scenario builds an expected per-cycle timeline of every output from the
// sequencing rules (instruction costs READ+LOAD+EXEC+NEXT plus datapath
// latency), drives start/mac_done/rst from the same timeline, and compares the
// DUT every cycle. A small memory + instruction register model supplies the
// flags. Hand-computed literals per scenario pin the timeline model.
// ----------------------------------------------------------------------------
module tb_ctrl_iseq;

   localparam int PCW  = 6;
   localparam int PLEN = 4;
   localparam int WDOG = 8;
   localparam int NCYC = 128;
`ifdef CTRL_ISEQ_WDOG_EN
   localparam bit WDOG_ON = 1'b1;
`else
   localparam bit WDOG_ON = 1'b0;
`endif

   logic           clk      = 1'b0;
   logic           rst      = 1'b0;
   logic           start    = 1'b0;
   logic           mac_done = 1'b0;
   logic           lstg_f   = 1'b0;
   logic           upse_f   = 1'b0;
   logic [PCW-1:0] imem_addr;
   logic           imem_rd, fetch, exec_go, out_strobe, sample_done, busy;
   logic [2:0]     err;

   always #5 clk = ~clk;

   ctrl_iseq #(
      .PCWIDTH    (PCW),
      .PROG_LEN   (PLEN),
      .WDOG_CYCLES(WDOG)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mac_done   (mac_done),
      .lstg_f     (lstg_f),
      .upse_f     (upse_f),
      .imem_addr  (imem_addr),
      .imem_rd    (imem_rd),
      .fetch      (fetch),
      .exec_go    (exec_go),
      .out_strobe (out_strobe),
      .sample_done(sample_done),
      .busy       (busy),
      .err        (err)
   );

   // Instruction memory (1-cycle read) and instruction register.
   bit   lstg_mem[PLEN];
   bit   upse_mem[PLEN];
   logic rd_lstg = 1'b0;
   logic rd_upse = 1'b0;

   always @(posedge clk) begin
      if (imem_rd === 1'b1) begin
         if (imem_addr < PCW'(PLEN)) begin
            rd_lstg <= lstg_mem[imem_addr[1:0]];
            rd_upse <= upse_mem[imem_addr[1:0]];
         end else begin
            rd_lstg <= 1'b0;
            rd_upse <= 1'b0;
         end
      end
      if (fetch === 1'b1) begin
         lstg_f <= rd_lstg;
         upse_f <= rd_upse;
      end
   end

   // Scenario timeline: drive vectors and expected outputs per cycle.
   bit             d_start[NCYC], d_mac[NCYC], d_rstlow[NCYC];
   bit             e_rd[NCYC], e_fetch[NCYC], e_go[NCYC];
   bit             e_out[NCYC], e_sd[NCYC], e_busy[NCYC];
   logic [PCW-1:0] e_addr[NCYC];
   logic [2:0]     e_err[NCYC];

   int checks = 0;
   int errors = 0;
   bit active = 1'b0;
   int cyc    = 0;

   // Observations gathered by the compare process.
   int             n_go, n_sd, n_out, sd_cyc, out_cyc, fall_cyc, snap_cyc;
   int             rd_addrs[$];
   logic [2:0]     last_err, snap_err;
   logic [PCW-1:0] last_addr, snap_addr;
   logic           last_busy, prev_busy, snap_busy;

   task automatic chk(input string name, input int c, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (active && (cyc >= 1)) begin
         chk("imem_rd", cyc, 32'(imem_rd), 32'(e_rd[cyc]));
         chk("fetch", cyc, 32'(fetch), 32'(e_fetch[cyc]));
         chk("exec_go", cyc, 32'(exec_go), 32'(e_go[cyc]));
         chk("out_strobe", cyc, 32'(out_strobe), 32'(e_out[cyc]));
         chk("sample_done", cyc, 32'(sample_done), 32'(e_sd[cyc]));
         chk("busy", cyc, 32'(busy), 32'(e_busy[cyc]));
         chk("imem_addr", cyc, 32'(imem_addr), 32'(e_addr[cyc]));
         chk("err", cyc, 32'(err), 32'(e_err[cyc]));
         if (exec_go === 1'b1) n_go++;
         if (sample_done === 1'b1) begin
            n_sd++;
            sd_cyc = cyc;
         end
         if (out_strobe === 1'b1) begin
            n_out++;
            out_cyc = cyc;
         end
         if (imem_rd === 1'b1) rd_addrs.push_back(int'(imem_addr));
         if ((prev_busy === 1'b1) && (busy === 1'b0)) fall_cyc = cyc;
         if (cyc == snap_cyc) begin
            snap_busy = busy;
            snap_addr = imem_addr;
            snap_err  = err;
         end
         prev_busy = busy;
         last_err  = err;
         last_addr = imem_addr;
         last_busy = busy;
      end
   end

   task automatic clear_scn();
      for (int c = 0; c < NCYC; c++) begin
         d_start[c] = 0; d_mac[c] = 0; d_rstlow[c] = 0;
         e_rd[c] = 0; e_fetch[c] = 0; e_go[c] = 0;
         e_out[c] = 0; e_sd[c] = 0; e_busy[c] = 0;
         e_addr[c] = '0; e_err[c] = '0;
      end
      d_rstlow[0] = 1;
      for (int i = 0; i < PLEN; i++) begin
         lstg_mem[i] = 0;
         upse_mem[i] = 0;
      end
   endtask

   task automatic set_err(input int c, input logic [2:0] b);
      for (int k = c; k < NCYC; k++) e_err[k] = e_err[k] | b;
   endtask

   task automatic fill(input int a, input int b, input int p);
      for (int k = a; k <= b; k++) begin
         e_busy[k] = 1;
         e_addr[k] = PCW'(p);
      end
   endtask

   // One program pass started by a start pulse at cycle ts; the datapath
   // answers lat cycles after each exec_go (optionally also pulsing mac_done
   // in the exec_go cycle itself, which must be ignored).
   task automatic model_run(input int ts, input int lat, input bit mac_in_go);
      int r, pc, g, m, nx, f;
      bit done;
      d_start[ts] = 1;
      r = ts + 1;
      pc = 0;
      done = 0;
      while (!done) begin
         g = r + 2;
         e_rd[r] = 1;
         e_fetch[r+1] = 1;
         e_go[g] = 1;
         if (mac_in_go) d_mac[g] = 1;
         if (WDOG_ON && (lat >= WDOG)) begin
            f = g + WDOG;
            fill(r, f - 1, pc);
            set_err(f, 3'b100);
            done = 1;
         end else begin
            m = g + lat;
            d_mac[m] = 1;
            nx = m + 1;
            f = nx + 1;
            fill(r, nx, pc);
            if (upse_mem[pc]) e_out[f] = 1;
            if (lstg_mem[pc]) begin
               e_sd[f] = 1;
               done = 1;
            end else if (pc == PLEN - 1) begin
               set_err(f, 3'b010);
               done = 1;
            end else begin
               pc++;
               r = f;
            end
         end
      end
   endtask

   task automatic start_overrun(input int s);
      d_start[s] = 1;
      if (e_busy[s]) set_err(s + 1, 3'b001);
   endtask

   task automatic reset_at(input int k);
      d_rstlow[k] = 1;
      for (int c = k + 1; c < NCYC; c++) begin
         d_start[c] = 0; d_mac[c] = 0;
         e_rd[c] = 0; e_fetch[c] = 0; e_go[c] = 0;
         e_out[c] = 0; e_sd[c] = 0; e_busy[c] = 0;
         e_addr[c] = '0; e_err[c] = '0;
      end
   endtask

   task automatic run_scn();
      n_go = 0; n_sd = 0; n_out = 0;
      sd_cyc = -1; out_cyc = -1; fall_cyc = -1;
      rd_addrs.delete();
      prev_busy = 1'b0;
      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         cyc      = c;
         rst      = ~d_rstlow[c];
         start    = d_start[c];
         mac_done = d_mac[c];
         active   = 1'b1;
      end
      @(posedge clk);
      #1;
      active   = 1'b0;
      start    = 1'b0;
      mac_done = 1'b0;
      rst      = 1'b1;
   endtask

   function automatic int rd_at(input int k);
      return (rd_addrs.size() > k) ? rd_addrs[k] : -1;
   endfunction

   initial begin
      snap_cyc = -1;

      // S1: lstg_f on word 2, datapath answers 5 cycles after exec_go.
      clear_scn();
      lstg_mem[2] = 1;
      model_run(2, 5, 0);
      run_scn();
      chk("s1_go_count", 0, n_go, 3);
      chk("s1_done_count", 0, n_sd, 1);
      chk("s1_done_cycle", 0, sd_cyc, 30);
      chk("s1_reads", 0, rd_addrs.size(), 3);
      chk("s1_addr0", 0, rd_at(0), 0);
      chk("s1_addr1", 0, rd_at(1), 1);
      chk("s1_addr2", 0, rd_at(2), 2);
      chk("s1_err", 0, 32'(last_err), 0);
      chk("s1_pc", 0, 32'(last_addr), 0);
      chk("s1_busy", 0, 32'(last_busy), 0);

      // S2: upse_f on words 0 and 2, lstg_f on word 2; stray mac_done in
      // every exec_go cycle.
      clear_scn();
      lstg_mem[2] = 1;
      upse_mem[0] = 1;
      upse_mem[2] = 1;
      model_run(2, 3, 1);
      run_scn();
      chk("s2_out_count", 0, n_out, 2);
      chk("s2_out_cycle", 0, out_cyc, 24);
      chk("s2_done_cycle", 0, sd_cyc, 24);
      chk("s2_go_count", 0, n_go, 3);

      // S3: no lstg_f anywhere -> program overrun.
      clear_scn();
      model_run(2, 2, 0);
      run_scn();
      chk("s3_go_count", 0, n_go, 4);
      chk("s3_done_count", 0, n_sd, 0);
      chk("s3_err", 0, 32'(last_err), 32'h2);
      chk("s3_idle_cycle", 0, fall_cyc, 27);
      chk("s3_pc", 0, 32'(last_addr), 0);

      // S4: start during EXEC of word 1.
      clear_scn();
      lstg_mem[2] = 1;
      model_run(2, 5, 0);
      start_overrun(16);
      run_scn();
      chk("s4_err", 0, 32'(last_err), 32'h1);
      chk("s4_done_count", 0, n_sd, 1);
      chk("s4_done_cycle", 0, sd_cyc, 30);

      // S5: start in the NEXT cycle that returns to IDLE.
      clear_scn();
      lstg_mem[2] = 1;
      model_run(2, 5, 0);
      start_overrun(29);
      run_scn();
      chk("s5_err", 0, 32'(last_err), 32'h1);
      chk("s5_go_count", 0, n_go, 3);
      chk("s5_idle_cycle", 0, fall_cyc, 30);

      // S6: overrun error, then reset during EXEC of word 1, then re-run.
      clear_scn();
      lstg_mem[2] = 1;
      model_run(2, 5, 0);
      start_overrun(15);
      reset_at(16);
      model_run(20, 5, 0);
      snap_cyc = 17;
      run_scn();
      snap_cyc = -1;
      chk("s6_rst_busy", 17, 32'(snap_busy), 0);
      chk("s6_rst_pc", 17, 32'(snap_addr), 0);
      chk("s6_rst_err", 17, 32'(snap_err), 0);
      chk("s6_rerun_addr", 0, rd_at(2), 0);
      chk("s6_done_count", 0, n_sd, 1);
      chk("s6_done_cycle", 0, sd_cyc, 48);
      chk("s6_go_count", 0, n_go, 5);

      // S7: datapath answers only after 60 cycles.
      clear_scn();
      lstg_mem[0] = 1;
      model_run(2, 60, 0);
      run_scn();
`ifdef CTRL_ISEQ_WDOG_EN
      chk("s7_err", 0, 32'(last_err), 32'h4);
      chk("s7_idle_cycle", 0, fall_cyc, 13);
      chk("s7_done_count", 0, n_sd, 0);
`else
      chk("s7_err", 0, 32'(last_err), 0);
      chk("s7_idle_cycle", 0, fall_cyc, 67);
      chk("s7_done_count", 0, n_sd, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
